// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// riscv_mem_pkg : shared types and defaults for the memory-port arbiter.
// Revision      : 1.0
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] BE_WORD          = 4'hF;
    localparam int         DEF_STARVE_LIMIT = 4;
    localparam int         DEF_TIMEOUT      = 16;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// mem_arb_pick : combinational winner select, data first unless fetch starved.
// Revision     : 1.0
// ============================================================================
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = 3
) (
    input  logic             if_req_i,
    input  logic             d_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             pick_if_o,
    output logic             pick_d_o
);

    logic w_force_if;

    assign w_force_if = if_req_i && (starve_cnt_i == CNT_W'(STARVE_LIMIT));
    assign pick_d_o   = d_req_i && !w_force_if;
    assign pick_if_o  = if_req_i && !pick_d_o;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and load/store.
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  m_req,
    output logic                  m_we,
    output logic [3:0]            m_be,
    output logic [DATA_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ack,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy
);

    localparam int              SC_W    = $clog2(STARVE_LIMIT + 1);
    localparam int              TC_W    = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [SC_W-1:0]       starve_q, starve_d;
    logic [TC_W-1:0]       tmo_q, tmo_d;
    logic                  m_we_q, m_we_d;
    logic [3:0]            m_be_q, m_be_d;
    logic [DATA_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;
    logic                  w_pick_if, w_pick_d, w_idle;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (SC_W)
    ) u_pick (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .starve_cnt_i (starve_q),
        .pick_if_o    (w_pick_if),
        .pick_d_o     (w_pick_d)
    );

    // Grants are combinational, so gate them with reset to keep every output low during reset.
    assign w_idle = (state_q == IDLE) && reset;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        m_we_d     = m_we_q;
        m_be_d     = m_be_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (w_idle && w_pick_d) begin
                    state_d   = REQ;
                    owner_d   = OWN_D;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q != SC_MAX)
                        starve_d = starve_q + 1'b1;
                end else if (w_idle && w_pick_if) begin
                    state_d   = REQ;
                    owner_d   = OWN_IF;
                    m_we_d    = 1'b0;
                    m_be_d    = BE_WORD;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    starve_d  = '0;
                end
            end
            REQ: begin
                // An ack on the last allowed cycle still completes normally.
                if (m_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (owner_q == OWN_D) d_rdata_d  = m_rdata;
                    else                  if_rdata_d = m_rdata;
                end else if (tmo_q == TC_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (owner_q == OWN_D) d_rdata_d  = '0;
                    else                  if_rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            starve_q   <= '0;
            tmo_q      <= '0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            m_we_q     <= m_we_d;
            m_be_q     <= m_be_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign if_gnt    = w_idle && w_pick_if;
    assign d_gnt     = w_idle && w_pick_d;
    assign m_req     = (state_q == REQ);
    assign busy      = (state_q != IDLE);
    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    assign if_err    = if_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign m_we      = m_we_q;
    assign m_be      = m_be_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : random requesters and memory, transaction-level model.
// Revision            : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LIM  = 4;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be, m_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mem_port_arbiter #(
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (LIM),
        .TIMEOUT      (TOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_be      (m_be),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own_d;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Model phase of the current cycle: 0 idle, 1 memory request, 2 response.
    int          ph = 0;
    int          j  = 0;
    int          k  = 0;
    int          kend = 0;
    int          starve = 0;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, ack_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fetch requester: holds if_req until granted, then maybe issues a new one.
    initial begin
        logic g;
        if_req  = 1'b0;
        if_addr = '0;
        forever begin
            @(negedge clk);
            g = if_gnt;
            @(posedge clk);
            #1;
            if (g) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 3) != 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
        end
    end

    // Data requester: re-requests almost every time so fetch starvation occurs.
    initial begin
        logic g;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        forever begin
            @(negedge clk);
            g = d_gnt;
            @(posedge clk);
            #1;
            if (g) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 7) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
        end
    end

    // Reference model and memory responder.
    initial begin
        bit    xd, xi;
        int    r;
        resp_t it;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ph = 0; starve = 0; m_ack = 1'b0;
                exp_q.delete();
                chk("rst_m_req",  m_req, 0);
                chk("rst_busy",   busy, 0);
                chk("rst_gnt",    {if_gnt, d_gnt}, 0);
                chk("rst_rvalid", {if_rvalid, d_rvalid, if_err, d_err}, 0);
                chk("rst_m_addr", m_addr, 0);
                chk("rst_m_ctl",  {m_we, m_be}, 0);
                chk("rst_rdata",  if_rdata | d_rdata, 0);
                continue;
            end
            m_rdata = $urandom;
            case (ph)
                0: begin
                    chk("idle_m_req", m_req, 0);
                    chk("idle_busy", busy, 0);
                    chk("missing_rvalid", exp_q.size(), 0);
                    exp_q.delete();
                    xd = d_req && !(if_req && starve == LIM);
                    xi = if_req && !xd;
                    chk("if_gnt", if_gnt, xi);
                    chk("d_gnt", d_gnt, xd);
                    if (xd || xi) begin
                        if (xd) begin
                            starve  = if_req ? ((starve < LIM) ? starve + 1 : LIM) : 0;
                            e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
                        end else begin
                            starve  = 0;
                            e_we = 1'b0; e_be = 4'hF; e_addr = if_addr; e_wdata = '0;
                        end
                        r        = $urandom_range(0, 9);
                        k        = (r < 7) ? $urandom_range(1, 4) : ((r == 7) ? TOUT : 99);
                        kend     = (k > TOUT) ? TOUT : k;
                        ack_data = $urandom;
                        it.own_d = xd;
                        it.err   = (k > TOUT);
                        it.rdata = (k > TOUT) ? 32'h0 : ack_data;
                        exp_q.push_back(it);
                        ph = 1;
                        j  = 0;
                    end
                    m_ack = ($urandom_range(0, 5) == 0);
                end
                1: begin
                    j++;
                    chk("req_m_req", m_req, 1);
                    chk("req_busy", busy, 1);
                    chk("req_gnt", {if_gnt, d_gnt}, 0);
                    chk("m_we", m_we, e_we);
                    chk("m_be", m_be, e_be);
                    chk("m_addr", m_addr, e_addr);
                    chk("m_wdata", m_wdata, e_wdata);
                    m_ack = (j == k);
                    if (m_ack) m_rdata = ack_data;
                    if (j == kend) ph = 2;
                end
                default: begin
                    chk("resp_m_req", m_req, 0);
                    chk("resp_busy", busy, 1);
                    chk("resp_gnt", {if_gnt, d_gnt}, 0);
                    m_ack = ($urandom_range(0, 3) == 0);
                    ph = 0;
                end
            endcase
        end
    end

    // Completion monitor: pops the expected response whenever rvalid appears.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (reset && (if_rvalid || d_rvalid)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", {if_rvalid, d_rvalid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_owner", {if_rvalid, d_rvalid}, e.own_d ? 2'b01 : 2'b10);
                    chk("rdata", e.own_d ? d_rdata : if_rdata, e.rdata);
                    chk("err", {if_err, d_err}, e.own_d ? {1'b0, e.err} : {e.err, 1'b0});
                end
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (1500) @(posedge clk);

        // Drop an in-flight transaction with an asynchronous reset.
        waited = 0;
        while (!(ph == 1 && j == 2) && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 300) begin
            chk("wait_for_req", 32'(waited), 0);
        end else begin
            #3 reset = 1'b0;
            #1;
            chk("midreq_m_req", m_req, 0);
            chk("midreq_busy", busy, 0);
            chk("midreq_rvalid", {if_rvalid, d_rvalid}, 0);
            repeat (2) @(posedge clk);
            #2 reset = 1'b1;
        end
        repeat (1500) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
